// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Constants and helpers shared by the memory arbiter files.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam logic [1:0]  BE_WORD = 2'b11;

  function automatic logic port_eligible(input logic req, input logic done);
    return req & ~done;
  endfunction

  // Advance (or a dropped request) beats a completion landing in the same cycle.
  function automatic logic next_done(input logic done, input logic req,
                                     input logic adv, input logic set);
    logic r;
    if (adv || !req) begin
      r = 1'b0;
    end else if (set) begin
      r = 1'b1;
    end else begin
      r = done;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU instruction/data ports plus the physical-memory port seen by the arbiter.
interface mem_arbiter_if;
  import lc3b_types::*;
  import mem_arbiter_pkg::*;

  logic                instruction_request;
  logic [ADDR_W-1:0]   instruction_address;
  lc3b_word            instr;
  logic                instruction_response;

  logic                data_request;
  logic                write_enable;
  logic [ADDR_W-1:0]   mem_address;
  lc3b_mem_wmask       mem_byte_enable;
  lc3b_word            write_data;
  lc3b_word            mem_rdata;
  logic                data_response;

  logic                advance;

  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_address;
  lc3b_mem_wmask       pmem_byte_enable;
  lc3b_word            pmem_wdata;
  lc3b_word            pmem_rdata;
  logic                pmem_resp;

  modport slave (
    input  instruction_request, instruction_address,
    output instr, instruction_response,
    input  data_request, write_enable, mem_address, mem_byte_enable, write_data,
    output mem_rdata, data_response,
    input  advance,
    output pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output instruction_request, instruction_address,
    input  instr, instruction_response,
    output data_request, write_enable, mem_address, mem_byte_enable, write_data,
    input  mem_rdata, data_response,
    output advance,
    input  pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/register.sv
// Loadable register with synchronous active-high clear.
module register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // Hold value, replaced only on load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU instruction and data ports onto one physical memory port; data wins ties.
module mem_arbiter
  import lc3b_types::*;
  import mem_arbiter_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IFETCH  = 2'b01,
    DACCESS = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_grant_data;
  logic               w_grant_instr;
  logic               w_access_done;
  logic               w_instr_load;
  logic               w_data_load;

  logic [ADDR_W-1:0]  r_addr;
  lc3b_mem_wmask      r_be;
  lc3b_word           r_wdata;
  logic               r_we;
  logic               r_pmem_read;
  logic               r_pmem_write;
  logic               r_instr_resp;
  logic               r_data_resp;
  logic               r_instr_done;
  logic               r_data_done;

  // Next-state and grant decode.
  always_comb begin
    w_state_next  = r_state;
    w_grant_data  = 1'b0;
    w_grant_instr = 1'b0;
    w_access_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (port_eligible(bus.data_request, r_data_done)) begin
          w_grant_data = 1'b1;
          w_state_next = DACCESS;
        end else if (port_eligible(bus.instruction_request, r_instr_done)) begin
          w_grant_instr = 1'b1;
          w_state_next  = IFETCH;
        end else begin
          w_state_next = IDLE;
        end
      end
      IFETCH, DACCESS: begin
        if (bus.pmem_resp) begin
          w_access_done = 1'b1;
          w_state_next  = IDLE;
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_instr_load = w_access_done && (r_state == IFETCH);
  assign w_data_load  = w_access_done && (r_state == DACCESS) && !r_we;

  // State, latched request, strobes, response pulses and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= 16'h0000;
      r_be         <= 2'b00;
      r_wdata      <= 16'h0000;
      r_we         <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_instr_resp <= 1'b0;
      r_data_resp  <= 1'b0;
      r_instr_done <= 1'b0;
      r_data_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_data) begin
        r_addr       <= bus.mem_address;
        r_be         <= bus.mem_byte_enable;
        r_wdata      <= bus.write_data;
        r_we         <= bus.write_enable;
        r_pmem_read  <= !bus.write_enable;
        r_pmem_write <= bus.write_enable;
      end else if (w_grant_instr) begin
        r_addr       <= bus.instruction_address;
        r_be         <= BE_WORD;
        r_we         <= 1'b0;
        r_pmem_read  <= 1'b1;
        r_pmem_write <= 1'b0;
      end else if (w_access_done) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
      end else begin
        r_pmem_read  <= r_pmem_read;
        r_pmem_write <= r_pmem_write;
      end
      r_instr_resp <= w_instr_load;
      r_data_resp  <= w_access_done && (r_state == DACCESS);
      r_instr_done <= next_done(r_instr_done, bus.instruction_request, bus.advance,
                                w_instr_load);
      r_data_done  <= next_done(r_data_done, bus.data_request, bus.advance,
                                w_access_done && (r_state == DACCESS));
    end
  end

  register #(.WIDTH(16)) u_instr_reg (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_instr_load),
    .i_data (bus.pmem_rdata),
    .o_data (bus.instr)
  );

  register #(.WIDTH(16)) u_rdata_reg (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_data_load),
    .i_data (bus.pmem_rdata),
    .o_data (bus.mem_rdata)
  );

  assign bus.pmem_read            = r_pmem_read;
  assign bus.pmem_write           = r_pmem_write;
  assign bus.pmem_address         = r_addr;
  assign bus.pmem_byte_enable     = r_be;
  assign bus.pmem_wdata           = r_wdata;
  assign bus.instruction_response = r_instr_resp;
  assign bus.data_response        = r_data_resp;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have CPU instruction port: instruction_request in 1; instruction_address in 16; instr out 16 (lc3b_word); instruction_response out 1.
REQ-003 SHALL have CPU data port: data_request in 1; write_enable in 1 (1=store); mem_address in 16; mem_byte_enable in 2; write_data in 16; mem_rdata out 16; data_response out 1.
REQ-004 SHALL have input advance, 1 bit: CPU pipeline advance strobe; retires completed requests.
REQ-005 SHALL have physical-memory port: pmem_read out 1; pmem_write out 1; pmem_address out 16; pmem_byte_enable out 2; pmem_wdata out 16; pmem_rdata in 16; pmem_resp in 1 (one-cycle completion pulse).

Function
REQ-006 SHALL implement states IDLE, IFETCH, DACCESS.
REQ-007 In IDLE, a port is eligible when its request=1 and its done flag=0; data port has priority over instruction port when both eligible.
REQ-008 On grant: latch address, byte enable (instruction: 2'b11), wdata, write_enable; enter IFETCH or DACCESS on the next edge.
REQ-009 In IFETCH/DACCESS: pmem_read (or pmem_write for stores) held high, pmem_* from latched values, until pmem_resp=1.
REQ-010 On pmem_resp=1: drop pmem strobes at the next edge; pulse the owning port's response for exactly one cycle; return to IDLE.
REQ-011 Read data SHALL be registered on pmem_resp; instr/mem_rdata valid in the response cycle and held until that port's next response.
REQ-012 Stores SHALL pulse data_response; mem_rdata unchanged.
REQ-013 Per-port done flag: set with that port's response; cleared when advance=1 or when that port's request=0; a done port SHALL NOT be re-granted.
REQ-014 advance and response in the same cycle: the flag clears (advance wins); the next request is eligible one cycle later.
REQ-015 Minimum latency: request rising edge to response = 2 cycles with pmem_resp returned in the first access cycle.
REQ-016 pmem_resp outside IFETCH/DACCESS SHALL be ignored.
REQ-017 CPU-side changes to address/data during an access SHALL NOT affect pmem_* (latched values used).
REQ-018 At most one pmem transaction outstanding; pmem_read and pmem_write never both high.
REQ-019 Both ports request continuously: grants alternate only as done flags permit; data is always served first within an advance window.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, pmem_read=pmem_write=0, both responses=0, done flags=0, instr=16'h0000, mem_rdata=16'h0000, latched address/wdata=0.
REQ-021 Reset mid-access SHALL abandon the transaction without a response; a pmem_resp arriving after reset is ignored per REQ-016.

Structure
REQ-022 lc3b_word SHALL come from lc3b_types; the state enum and done flags SHALL stay local to the module.
REQ-023 Read-data hold registers SHALL instantiate the existing register module (width 16); no other sub-module.

Verification
REQ-024 Instruction fetch only: instruction_request=1, instruction_address=16'h0060, pmem_resp returned 3 cycles later with pmem_rdata=16'h1234 -> pmem_read=1, pmem_address=16'h0060, pmem_byte_enable=2'b11; instruction_response one cycle; instr=16'h1234 held.
REQ-025 Simultaneous requests: ifetch 16'h0062, load 16'h2000 -> data served first (pmem_address 16'h2000), then 16'h0062; each response exactly one pulse.
REQ-026 Store: data_request=1, write_enable=1, mem_address=16'h3000, mem_byte_enable=2'b01, write_data=16'hBEEF -> pmem_write=1 with those values; pmem_read=0; data_response pulses; mem_rdata unchanged.
REQ-027 Request held high with advance=0 for 10 cycles after response -> no second pmem transaction; advance=1 with new address 16'h0064 -> new fetch starts.
REQ-028 rst asserted during DACCESS, pmem_resp arrives next cycle -> no data_response; all outputs at REQ-020 values.
REQ-029 Address changed mid-access (16'h0060 -> 16'h0080) -> pmem_address stays 16'h0060 until pmem_resp.
